acq_controller: RTL
===================

# acq_controller

Acquisition controller for the pulse-registration datapath. It sequences the timestamp counter's `clear`/`operate` controls for timed or open-ended runs. It filters the 41-bit click records by per-channel mask and forwards them into the downstream record FIFO, dropping and accounting for records when the FIFO is full. It sits between the host command registers and the registration block / record FIFO.

## Interface
- `DUR_W`, default 40: width of run-duration counter (clk cycles).
- `CNT_W`, default 32: width of accepted-record counter.
- `clk`  in  1: system clock, all logic on posedge.
- `reset`  in  1: synchronous, active-high; returns block to IDLE.
- `start_cmd`  in  1: one-cycle pulse, begin a run.
- `stop_cmd`  in  1: one-cycle pulse, end a run early.
- `duration`  in  DUR_W: run length in cycles, sampled at start; 0 = unlimited.
- `channel_mask`  in  4: per-channel enable, sampled at start.
- `timer_clear`  out  1: drives registration block `clear`.
- `timer_operate`  out  1: drives registration block `operate`.
- `rec_ready`  in  1: record-valid strobe from registration block.
- `rec_data`  in  41: record; [40:37] channels, [36] zero-time marker, [35:0] timestamp.
- `fifo_wr`  out  1: write strobe to record FIFO.
- `fifo_data`  out  41: record to FIFO.
- `fifo_full`  in  1: FIFO cannot accept a write this cycle.
- `running`  out  1: high in CLEAR, RUN, FLUSH.
- `done`  out  1: one-cycle pulse at run end.
- `overflow`  out  1: sticky; set on any dropped record, cleared by next start.
- `rec_count`  out  CNT_W: records written this run, saturating.

## Operation
- States: IDLE, CLEAR, RUN, FLUSH.
- IDLE: `start_cmd` without `stop_cmd` -> CLEAR. Latch `duration` and `channel_mask`; zero `rec_count`, `overflow`, lost count. `start_cmd` and `stop_cmd` together in IDLE: no action.
- CLEAR, one cycle: `timer_clear`=1, `timer_operate`=1. Next state RUN. The registration block then emits its zero-time marker record.
- RUN: `timer_operate`=1, `timer_clear`=0. Duration counter loads `duration`, decrements each RUN cycle. RUN -> FLUSH on `stop_cmd`, or when counter==1 with nonzero `duration`. `start_cmd` is ignored.
- FLUSH, 2 cycles: `timer_operate`=0; in-flight records are still accepted. Then `done`=1 for one cycle -> IDLE.
- Record filter, active while `running` or on the first IDLE cycle after FLUSH:
  - masked = `rec_data[40:37]` & latched mask.
  - Forward if masked != 0 or `rec_data[36]`=1. Forwarded record carries masked channels in [40:37]; [36:0] unchanged.
  - Otherwise drop silently, no accounting.
- Forwarded record while `fifo_full`=1: no write; `overflow` set; lost count incremented.
- `rec_count` increments per write and saturates at all-ones. Timestamp wrap (marker records with channel 0 during RUN) is forwarded like any marker.
- `reset` mid-run: IDLE next cycle. All outputs 0, counters 0; no `done` pulse.

## Timing
- Reset values: every output 0.
- Filter latency 1 cycle: `rec_ready` at edge N -> `fifo_wr`/`fifo_data` valid after edge N+1. `fifo_full` is sampled at edge N.
- `fifo_wr` asserted only for single cycles; no backpressure toward the registration block.
- `start_cmd` at edge N -> `timer_clear` high N+1..N+2 -> RUN from N+2.
- Nonzero `duration` D gives exactly D RUN cycles.
- `done` occurs 3 cycles after leaving RUN.

## Configuration
- `ACQ_LOST_COUNT_EN` defined:
  - adds output `lost_count` (CNT_W, saturating, zeroed at start and reset) counting records dropped on `fifo_full`.
- Undefined:
  - port and counter absent; only sticky `overflow` reports drops.

## Structure
- Package `acq_pkg`:
  - state enum;
  - `REC_W`=41;
  - field constants `CH_MSB`=40, `CH_LSB`=37, `MARKER_BIT`=36, `TS_W`=36.
- One sub-module: `acq_record_filter`. It contains mask, forward decision, registered FIFO write, `rec_count`/lost-count saturation, and `overflow`. The top holds the FSM and duration counter.

## Test plan
- `duration`=5, mask 4'b1111, start -> `timer_clear` 1 cycle, exactly 5 RUN cycles, `done` pulse 3 cycles later, `running` low after.
- Mask 4'b0011; records with channel 4'b0100 then 4'b0110 -> first dropped, second written as 4'b0010; marker record with channel 0 written; `rec_count`=2.
- `duration`=0, records each cycle, `stop_cmd` after 10 cycles -> FLUSH; record arriving in the FLUSH cycle written; none after IDLE+1.
- `fifo_full` held 3 cycles during 3 valid records -> no writes, `overflow`=1, `lost_count`=3 (macro on); next start clears both.
- `reset` pulsed mid-RUN with 4 records counted -> next cycle all outputs 0, no `done`.
- `start_cmd` with `stop_cmd` same cycle in IDLE -> stays IDLE; `start_cmd` during RUN -> counter not reloaded.

Source files
------------

// File: rtl/acq_pkg.sv
// Shared types and record field layout for the acquisition controller.
package acq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } acq_state_t;

    localparam int REC_W      = 41;
    localparam int CH_MSB     = 40;
    localparam int CH_LSB     = 37;
    localparam int MARKER_BIT = 36;
    localparam int TS_W       = 36;

endpackage

// File: rtl/acq_record_filter.sv
// Channel-mask record filter with registered FIFO write, saturating counters
// and sticky overflow. Optional lost-record counter under ACQ_LOST_COUNT_EN.
module acq_record_filter
    import acq_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [3:0]        mask_in,
    input  logic              enable,
    input  logic              rec_ready,
    input  logic [REC_W-1:0]  rec_data,
    input  logic              fifo_full,
    output logic              fifo_wr,
    output logic [REC_W-1:0]  fifo_data,
    output logic              overflow,
    output logic [CNT_W-1:0]  rec_count
`ifdef ACQ_LOST_COUNT_EN
    , output logic [CNT_W-1:0] lost_count
`endif
);

    logic [3:0]       mask_reg;
    logic [3:0]       masked;
    logic             forward;
    logic             write;
    logic             fifo_wr_reg;
    logic [REC_W-1:0] fifo_data_reg;
    logic             overflow_reg;
    logic [CNT_W-1:0] rec_count_reg;

    assign masked  = rec_data[CH_MSB:CH_LSB] & mask_reg;
    assign forward = enable && rec_ready && ((masked != 4'd0) || rec_data[MARKER_BIT]);
    assign write   = forward && !fifo_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_reg      <= '0;
            fifo_wr_reg   <= 1'b0;
            fifo_data_reg <= '0;
            overflow_reg  <= 1'b0;
            rec_count_reg <= '0;
        end else begin
            fifo_wr_reg <= write;
            if (write) begin
                fifo_data_reg <= {masked, rec_data[MARKER_BIT], rec_data[TS_W-1:0]};
            end
            // A new run wipes the accounting; it takes priority over a same-cycle record.
            if (load) begin
                mask_reg      <= mask_in;
                overflow_reg  <= 1'b0;
                rec_count_reg <= '0;
            end else if (forward) begin
                if (fifo_full) begin
                    overflow_reg <= 1'b1;
                end else if (rec_count_reg != {CNT_W{1'b1}}) begin
                    rec_count_reg <= rec_count_reg + 1'b1;
                end
            end
        end
    end

`ifdef ACQ_LOST_COUNT_EN
    logic [CNT_W-1:0] lost_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            lost_count_reg <= '0;
        end else if (load) begin
            lost_count_reg <= '0;
        end else if (forward && fifo_full && (lost_count_reg != {CNT_W{1'b1}})) begin
            lost_count_reg <= lost_count_reg + 1'b1;
        end
    end

    assign lost_count = lost_count_reg;
`endif

    assign fifo_wr   = fifo_wr_reg;
    assign fifo_data = fifo_data_reg;
    assign overflow  = overflow_reg;
    assign rec_count = rec_count_reg;

endmodule

// File: rtl/acq_controller.sv
// Acquisition run sequencer: drives timer clear/operate, times runs and feeds
// the record filter. Define ACQ_LOST_COUNT_EN to add the lost_count output.
module acq_controller
    import acq_pkg::*;
#(
    parameter int DUR_W = 40,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_cmd,
    input  logic              stop_cmd,
    input  logic [DUR_W-1:0]  duration,
    input  logic [3:0]        channel_mask,
    output logic              timer_clear,
    output logic              timer_operate,
    input  logic              rec_ready,
    input  logic [REC_W-1:0]  rec_data,
    output logic              fifo_wr,
    output logic [REC_W-1:0]  fifo_data,
    input  logic              fifo_full,
    output logic              running,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  rec_count
`ifdef ACQ_LOST_COUNT_EN
    , output logic [CNT_W-1:0] lost_count
`endif
);

    acq_state_t       state_reg, state_next;
    logic [DUR_W-1:0] dur_cnt_reg;
    logic             unlimited_reg;
    logic             flush_cnt_reg;
    logic             done_reg;
    logic             start_run;

    always_comb begin
        state_next    = state_reg;
        start_run     = 1'b0;
        timer_clear   = 1'b0;
        timer_operate = 1'b0;
        running       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_cmd && !stop_cmd) begin
                    start_run  = 1'b1;
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                timer_clear   = 1'b1;
                timer_operate = 1'b1;
                running       = 1'b1;
                state_next    = ST_RUN;
            end
            ST_RUN: begin
                timer_operate = 1'b1;
                running       = 1'b1;
                if (stop_cmd || (!unlimited_reg && dur_cnt_reg == DUR_W'(1))) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                running = 1'b1;
                if (flush_cnt_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            dur_cnt_reg   <= '0;
            unlimited_reg <= 1'b0;
            flush_cnt_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            done_reg      <= (state_reg == ST_FLUSH) && flush_cnt_reg;
            flush_cnt_reg <= (state_reg == ST_FLUSH) ? ~flush_cnt_reg : 1'b0;
            // Counter only loads from IDLE, so a start during RUN cannot extend the run.
            if (start_run) begin
                dur_cnt_reg   <= duration;
                unlimited_reg <= (duration == '0);
            end else if (state_reg == ST_RUN) begin
                dur_cnt_reg <= dur_cnt_reg - 1'b1;
            end
        end
    end

    assign done = done_reg;

    // The done cycle is the first IDLE cycle; late records are still taken then.
    acq_record_filter #(
        .CNT_W (CNT_W)
    ) u_filter (
        .clk        (clk),
        .reset      (reset),
        .load       (start_run),
        .mask_in    (channel_mask),
        .enable     (running || done_reg),
        .rec_ready  (rec_ready),
        .rec_data   (rec_data),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_data  (fifo_data),
        .overflow   (overflow),
        .rec_count  (rec_count)
`ifdef ACQ_LOST_COUNT_EN
        , .lost_count (lost_count)
`endif
    );

endmodule
